// File: rtl/token_enq_arbiter.sv
// Round-robin arbiter draining per-requester saturating token counters into a FIFO enqueue port.
// Define TOKEN_ENQ_ARB_FIXED_PRIO_EN for fixed priority (lowest eligible index wins, no pointer).
module token_enq_arbiter #(
  parameter int nReq     = 4,
  parameter int idxWidth = 2,
  parameter int cntWidth = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [nReq-1:0]     REQ,
  output logic [nReq-1:0]     PEND_FULL_N,
  output logic                fENQ,
  input  logic                fFULL_N,
  output logic [nReq-1:0]     GRANT,
  output logic [idxWidth-1:0] GRANT_IDX,
  output logic                IDLE
);

  localparam logic [cntWidth-1:0] cntMax = '1;

  logic [cntWidth-1:0] cnt [nReq];
  logic [nReq-1:0]     elig;
  logic [nReq-1:0]     accepted;
  logic [idxWidth-1:0] winIdx;
  logic                found;

  always_comb begin
    elig        = '0;
    PEND_FULL_N = '0;
    accepted    = '0;
    for (int unsigned i = 0; i < nReq; i++) begin
      elig[i]        = (cnt[i] != '0);
      PEND_FULL_N[i] = (cnt[i] != cntMax) & ~RST;
      accepted[i]    = REQ[i] & PEND_FULL_N[i];
    end
    IDLE = ~(|elig) | RST;
    fENQ = fFULL_N & (|elig) & ~RST;
  end

`ifdef TOKEN_ENQ_ARB_FIXED_PRIO_EN
  always_comb begin
    winIdx = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < nReq; i++) begin
      if (!found && elig[i]) begin
        winIdx = idxWidth'(i);
        found  = 1'b1;
      end
    end
  end
`else
  localparam logic [idxWidth:0]   nReqW   = (idxWidth+1)'(nReq);
  localparam logic [idxWidth-1:0] lastIdx = idxWidth'(nReq - 1);

  logic [idxWidth-1:0] ptr;
  logic [idxWidth:0]   cand;

  // Search ptr, ptr+1, ... modulo nReq; one extra bit keeps the wrap exact for non-power-of-2 nReq.
  always_comb begin
    winIdx = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned off = 0; off < nReq; off++) begin
      cand = {1'b0, ptr} + (idxWidth+1)'(off);
      if (cand >= nReqW) cand = cand - nReqW;
      if (!found && elig[cand[idxWidth-1:0]]) begin
        winIdx = cand[idxWidth-1:0];
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= '0;
    end else if (fENQ) begin
      ptr <= (winIdx == lastIdx) ? '0 : winIdx + idxWidth'(1);
    end
  end
`endif

  always_comb begin
    GRANT     = '0;
    GRANT_IDX = fENQ ? winIdx : '0;
    for (int unsigned i = 0; i < nReq; i++) begin
      GRANT[i] = fENQ & (winIdx == idxWidth'(i));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < nReq; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < nReq; i++) begin
        case ({accepted[i], GRANT[i]})
          2'b10:   cnt[i] <= cnt[i] + cntWidth'(1);
          2'b01:   cnt[i] <= cnt[i] - cntWidth'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_token_enq_arbiter.sv
// Directed bench for token_enq_arbiter: reset, single token, arbitration order, saturation,
// simultaneous post/grant, backpressure and mid-stream reset.
module tb_token_enq_arbiter;

  logic       CLK;
  logic       RST;
  logic [3:0] REQ;
  logic [3:0] PEND_FULL_N;
  logic       fENQ;
  logic       fFULL_N;
  logic [3:0] GRANT;
  logic [1:0] GRANT_IDX;
  logic       IDLE;

  int checks = 0;
  int errors = 0;

  token_enq_arbiter #(.nReq(4), .idxWidth(2), .cntWidth(3)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .PEND_FULL_N(PEND_FULL_N), .fENQ(fENQ),
    .fFULL_N(fFULL_N), .GRANT(GRANT), .GRANT_IDX(GRANT_IDX), .IDLE(IDLE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ = 4'b1111; fFULL_N = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      checks++;
      if (fENQ !== 1'b0) begin errors++; $display("FAIL reset_fenq cyc%0d got %b want 0", c, fENQ); end
      checks++;
      if (PEND_FULL_N !== 4'b0000) begin errors++; $display("FAIL reset_pfn cyc%0d got %b want 0000", c, PEND_FULL_N); end
      checks++;
      if (IDLE !== 1'b1 || GRANT !== 4'b0000 || GRANT_IDX !== 2'd0) begin
        errors++; $display("FAIL reset_outs cyc%0d idle=%b grant=%b idx=%0d want 1/0000/0", c, IDLE, GRANT, GRANT_IDX);
      end
    end
    step();
    RST = 1'b0; REQ = 4'b0000;
    #1;
    checks++;
    if (IDLE !== 1'b1 || fENQ !== 1'b0 || GRANT !== 4'b0000) begin
      errors++; $display("FAIL post_reset idle=%b fenq=%b grant=%b want 1/0/0000", IDLE, fENQ, GRANT);
    end
    checks++;
    if (PEND_FULL_N !== 4'b1111) begin errors++; $display("FAIL post_reset_pfn got %b want 1111", PEND_FULL_N); end
  endtask

  task automatic test_single();
    step();
    REQ = 4'b0100;
    step();
    REQ = 4'b0000;
    #1;
    checks++;
    if (fENQ !== 1'b1 || GRANT !== 4'b0100 || GRANT_IDX !== 2'd2) begin
      errors++; $display("FAIL single_grant fenq=%b grant=%b idx=%0d want 1/0100/2", fENQ, GRANT, GRANT_IDX);
    end
    step();
    #1;
    checks++;
    if (IDLE !== 1'b1 || fENQ !== 1'b0 || GRANT_IDX !== 2'd0) begin
      errors++; $display("FAIL single_idle idle=%b fenq=%b idx=%0d want 1/0/0", IDLE, fENQ, GRANT_IDX);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] expSeq [8];
`ifdef TOKEN_ENQ_ARB_FIXED_PRIO_EN
    expSeq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
`else
    expSeq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
`endif
    step();
    RST = 1'b1; fFULL_N = 1'b0; REQ = 4'b0000;
    step();
    RST = 1'b0; REQ = 4'b1111;
    step();
    step();
    REQ = 4'b0000; fFULL_N = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      #1;
      checks++;
      if (fENQ !== 1'b1 || GRANT_IDX !== expSeq[k] || GRANT !== (4'b0001 << expSeq[k])) begin
        errors++; $display("FAIL rr_grant%0d fenq=%b idx=%0d grant=%b want idx %0d", k, fENQ, GRANT_IDX, GRANT, expSeq[k]);
      end
    end
    step();
    #1;
    checks++;
    if (IDLE !== 1'b1 || fENQ !== 1'b0) begin errors++; $display("FAIL rr_idle idle=%b fenq=%b want 1/0", IDLE, fENQ); end
  endtask

  task automatic test_saturation();
    int grants = 0;
    fFULL_N = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step();
      REQ = 4'b0010;
      #1;
      checks++;
      if (PEND_FULL_N[1] !== (k < 7)) begin
        errors++; $display("FAIL sat_pfn after %0d posts got %b want %b", k, PEND_FULL_N[1], (k < 7));
      end
    end
    step();
    REQ = 4'b0000; fFULL_N = 1'b1;
    #1;
    checks++;
    if (PEND_FULL_N[1] !== 1'b0 || GRANT !== 4'b0010) begin
      errors++; $display("FAIL sat_first_grant pfn1=%b grant=%b want 0/0010", PEND_FULL_N[1], GRANT);
    end
    for (int k = 0; k < 10; k++) begin
      if (fENQ === 1'b1 && GRANT === 4'b0010) grants++;
      if (k == 1) begin
        checks++;
        if (PEND_FULL_N[1] !== 1'b1) begin errors++; $display("FAIL sat_reopen got %b want 1", PEND_FULL_N[1]); end
      end
      step();
      #1;
    end
    checks++;
    if (grants != 7) begin errors++; $display("FAIL sat_grant_count got %0d want 7", grants); end
    checks++;
    if (IDLE !== 1'b1) begin errors++; $display("FAIL sat_idle got %b want 1", IDLE); end
  endtask

  task automatic test_simultaneous();
    step();
    REQ = 4'b0001; fFULL_N = 1'b0;
    step();
    fFULL_N = 1'b1;
    #1;
    checks++;
    if (GRANT !== 4'b0001) begin errors++; $display("FAIL simul_grant1 got %b want 0001", GRANT); end
    step();
    REQ = 4'b0000;
    #1;
    checks++;
    if (GRANT !== 4'b0001 || IDLE !== 1'b0) begin
      errors++; $display("FAIL simul_grant2 grant=%b idle=%b want 0001/0", GRANT, IDLE);
    end
    step();
    #1;
    checks++;
    if (IDLE !== 1'b1 || fENQ !== 1'b0) begin errors++; $display("FAIL simul_idle idle=%b fenq=%b want 1/0", IDLE, fENQ); end
  endtask

  task automatic test_backpressure();
    int remaining = 3;
    logic expEnq;
    step();
    fFULL_N = 1'b0; REQ = 4'b1000;
    step();
    step();
    step();
    REQ = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      fFULL_N = (k % 2 == 0);
      #1;
      expEnq = fFULL_N && (remaining > 0);
      checks++;
      if (fENQ !== expEnq || GRANT !== (expEnq ? 4'b1000 : 4'b0000)) begin
        errors++; $display("FAIL bp_cyc%0d fenq=%b grant=%b want fenq %b", k, fENQ, GRANT, expEnq);
      end
      if (expEnq) remaining--;
    end
    checks++;
    if (IDLE !== 1'b1) begin errors++; $display("FAIL bp_idle got %b want 1", IDLE); end

    step();
    fFULL_N = 1'b0; REQ = 4'b0110;
    step();
    step();
    REQ = 4'b0000; RST = 1'b1; fFULL_N = 1'b1;
    #1;
    checks++;
    if (fENQ !== 1'b0 || IDLE !== 1'b1 || PEND_FULL_N !== 4'b0000) begin
      errors++; $display("FAIL rst_mid fenq=%b idle=%b pfn=%b want 0/1/0000", fENQ, IDLE, PEND_FULL_N);
    end
    step();
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (fENQ !== 1'b0 || IDLE !== 1'b1) begin
        errors++; $display("FAIL rst_after%0d fenq=%b idle=%b want 0/1", k, fENQ, IDLE);
      end
      step();
    end
  endtask

  initial begin
    RST = 1'b1; REQ = 4'b0000; fFULL_N = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_saturation();
    test_simultaneous();
    test_backpressure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
